// File: rtl/matinv_stream_ctrl.sv
// Stream-side controller for one matinvN core: gathers an NxN matrix from an element
// stream, runs the core through its rst/ready/complete handshake and streams the result back.
//
// state  | meaning
// LOAD   | accepting input elements into core_matrix
// LAUNCH | core_rst high, waiting for core_ready
// WAIT   | core running, timeout counter active
// UNLOAD | presenting result beats (E beats, or one flagged beat)
module matinv_stream_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int BIN_POS     = 16,
    parameter int MATRIX_SIZE = 3,
    parameter int TIMEOUT     = 4096
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            s_valid,
    output logic                                            s_ready,
    input  logic [DATA_WIDTH-1:0]                           s_data,
    output logic                                            m_valid,
    input  logic                                            m_ready,
    output logic [DATA_WIDTH-1:0]                           m_data,
    output logic                                            m_last,
    output logic                                            m_singular,
    output logic                                            m_timeout,
    output logic                                            core_rst,
    input  logic                                            core_ready,
    input  logic                                            core_complete,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   core_matrix,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   core_inv,
    input  logic                                            core_singular
);

    localparam int E     = MATRIX_SIZE * MATRIX_SIZE;
    localparam int CNT_W = (E > 1) ? $clog2(E) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    if (MATRIX_SIZE < 1 || TIMEOUT < 2 || BIN_POS >= DATA_WIDTH) begin : g_param_check
        $error("matinv_stream_ctrl: invalid parameter combination");
    end

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [TMR_W-1:0]        tmr;
    logic [E*DATA_WIDTH-1:0] cap;
    logic                    cap_sing;
    logic                    cap_tmo;

    logic s_hs;
    logic m_hs;
    logic cnt_last;
    logic tmr_last;
    logic abort_job;
    logic cmpl_ok;

    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;
    assign cnt_last  = (cnt == CNT_W'(E - 1));
    assign tmr_last  = (tmr == TMR_W'(TIMEOUT - 1));
    assign abort_job = cap_sing | cap_tmo;
    // The first WAIT cycle has tmr==0; a complete seen there belongs to the previous job.
    assign cmpl_ok   = core_complete & (tmr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (s_hs && cnt_last) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (core_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmpl_ok || tmr_last) begin
                    state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (m_hs && (abort_job || cnt_last)) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            tmr         <= '0;
            core_matrix <= '0;
            cap         <= '0;
            cap_sing    <= 1'b0;
            cap_tmo     <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_hs) begin
                        core_matrix[cnt*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                        cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
                    end
                end
                ST_LAUNCH: begin
                    tmr <= '0;
                end
                ST_WAIT: begin
                    tmr <= tmr + TMR_W'(1);
                    // Complete takes priority over a coincident timeout.
                    if (cmpl_ok) begin
                        cap      <= core_inv;
                        cap_sing <= core_singular;
                        cap_tmo  <= 1'b0;
                    end else if (tmr_last) begin
                        cap_sing <= 1'b0;
                        cap_tmo  <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (m_hs) begin
                        cnt <= (abort_job || cnt_last) ? '0 : cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready    = (state == ST_LOAD) & ~rst;
        core_rst   = (state == ST_LAUNCH);
        m_valid    = (state == ST_UNLOAD);
        m_last     = m_valid & (abort_job | cnt_last);
        m_singular = m_valid & cap_sing;
        m_timeout  = m_valid & cap_tmo;
        m_data     = '0;
        if (m_valid && !abort_job) begin
            m_data = cap[cnt*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_matinv_stream_ctrl.sv
// Bench for matinv_stream_ctrl: a behavioural stand-in core that inverts diagonal matrices
// and flags everything else singular, driven by directed and $urandom jobs.
module tb_matinv_stream_ctrl;

    localparam int DW  = 32;
    localparam int N   = 3;
    localparam int E   = N * N;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic            m_last;
    logic            m_singular;
    logic            m_timeout;
    logic            core_rst;
    logic            core_ready    = 1'b0;
    logic            core_complete = 1'b0;
    logic [E*DW-1:0] core_matrix;
    logic [E*DW-1:0] core_inv      = '0;
    logic            core_singular = 1'b0;

    always #5 clk = ~clk;

    matinv_stream_ctrl #(
        .DATA_WIDTH (DW),
        .BIN_POS    (16),
        .MATRIX_SIZE(N),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_singular   (m_singular),
        .m_timeout    (m_timeout),
        .core_rst     (core_rst),
        .core_ready   (core_ready),
        .core_complete(core_complete),
        .core_matrix  (core_matrix),
        .core_inv     (core_inv),
        .core_singular(core_singular)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core behaviour: diagonal with positive entries is invertible, anything else singular.
    function automatic bit diag_ok(input logic [E*DW-1:0] m);
        logic [DW-1:0] el;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                el = m[(r*N+c)*DW +: DW];
                if (r == c && (el == '0 || el[DW-1])) return 1'b0;
                if (r != c && el != '0) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [E*DW-1:0] diag_inverse(input logic [E*DW-1:0] m);
        logic [E*DW-1:0] res;
        logic [63:0]     q;
        res = '0;
        for (int i = 0; i < N; i++) begin
            q = 64'h1_0000_0000 / {32'd0, m[(i*N+i)*DW +: DW]};
            res[(i*N+i)*DW +: DW] = q[DW-1:0];
        end
        return res;
    endfunction

    // Stand-in core; complete stays high (stale) until the next job's ready phase ends.
    int              stub_rdy_delay  = 0;
    int              stub_busy_delay = 0;
    bit              stub_hang       = 1'b0;
    int              phase           = 0;
    int              rcnt            = 0;
    int              bcnt            = 0;
    logic [E*DW-1:0] stub_mat        = '0;

    always @(posedge clk) begin
        case (phase)
            1: begin
                if (rcnt == 0) begin
                    core_ready <= 1'b1;
                    stub_mat   <= core_matrix;
                    phase      <= 2;
                end else begin
                    rcnt <= rcnt - 1;
                end
            end
            2: begin
                if (!core_rst) begin
                    core_ready    <= 1'b0;
                    core_complete <= 1'b0;
                    bcnt          <= stub_busy_delay;
                    phase         <= 3;
                end
            end
            default: begin
                if (core_rst) begin
                    rcnt  <= stub_rdy_delay;
                    phase <= 1;
                end else if (phase == 3 && !stub_hang) begin
                    if (bcnt == 0) begin
                        core_complete <= 1'b1;
                        core_singular <= !diag_ok(stub_mat);
                        core_inv      <= diag_ok(stub_mat) ? diag_inverse(stub_mat) : {E{32'hDEAD_BEEF}};
                        phase         <= 0;
                    end else begin
                        bcnt <= bcnt - 1;
                    end
                end
            end
        endcase
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic          sing;
        logic          tmo;
    } beat_t;

    // rmode: 0 always ready, 1 toggle every cycle, 2 random
    task automatic run_job(input string tag, input logic [E*DW-1:0] mat, input int rdy_d,
                           input int busy_d, input bit hang, input bit gaps, input int rmode,
                           input bit rst_beat4);
        beat_t           exp_q[$];
        beat_t           b;
        logic [E*DW-1:0] inv;
        bit              timed_out;
        int              exp_wait;
        int              k;
        int              launch;
        int              waitc;
        int              idx;
        int              guard;
        bit              stalled;
        logic [DW-1:0]   held;

        stub_rdy_delay  = rdy_d;
        stub_busy_delay = busy_d;
        stub_hang       = hang;

        timed_out = hang || (busy_d + 3 > TMO);
        exp_wait  = timed_out ? TMO : busy_d + 3;
        if (timed_out) begin
            exp_q.push_back('{d: '0, last: 1'b1, sing: 1'b0, tmo: 1'b1});
        end else if (!diag_ok(mat)) begin
            exp_q.push_back('{d: '0, last: 1'b1, sing: 1'b1, tmo: 1'b0});
        end else begin
            inv = diag_inverse(mat);
            for (int i = 0; i < E; i++)
                exp_q.push_back('{d: inv[i*DW +: DW], last: (i == E-1), sing: 1'b0, tmo: 1'b0});
        end

        for (int i = 0; i < E; i++) begin
            if (gaps && i > 0) begin
                s_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = mat[i*DW +: DW];
            k = 0;
            while (!s_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) begin
                check_eq({tag, " s_ready_wait"}, 64'(s_ready), 64'd1);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check_eq({tag, " s_ready_launch"}, 64'(s_ready), 64'd0);

        launch = 0;
        while (core_rst && launch < 100) begin
            launch++;
            @(negedge clk);
        end
        check_eq({tag, " launch_cycles"}, 64'(launch), 64'(rdy_d + 3));
        waitc = 0;
        while (!m_valid && !core_rst && waitc < 100) begin
            waitc++;
            @(negedge clk);
        end
        check_eq({tag, " wait_cycles"}, 64'(waitc), 64'(exp_wait));

        idx     = 0;
        guard   = 0;
        stalled = 1'b0;
        held    = '0;
        while (idx < exp_q.size() && guard < 400) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (stalled)
                check_eq($sformatf("%s hold%0d", tag, idx), {31'd0, m_valid, m_data}, {31'd0, 1'b1, held});
            if (rst_beat4 && idx == 3 && m_valid) begin
                rst     = 1'b1;
                m_ready = 1'b0;
                @(negedge clk);
                check_eq({tag, " rst_m_valid"}, 64'(m_valid), 64'd0);
                check_eq({tag, " rst_s_ready"}, 64'(s_ready), 64'd0);
                rst = 1'b0;
                @(negedge clk);
                check_eq({tag, " post_rst_s_ready"}, 64'(s_ready), 64'd1);
                check_eq({tag, " post_rst_m_valid"}, 64'(m_valid), 64'd0);
                return;
            end
            if (m_valid && m_ready) begin
                b = exp_q[idx];
                check_eq($sformatf("%s beat%0d", tag, idx),
                         64'({m_data, m_last, m_singular, m_timeout}), 64'(b));
                idx++;
                stalled = 1'b0;
            end else if (m_valid) begin
                stalled = 1'b1;
                held    = m_data;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) check_eq({tag, " unload_bound"}, 64'(idx), 64'(exp_q.size()));
        m_ready = 1'b0;
        check_eq({tag, " end_m_valid"}, 64'(m_valid), 64'd0);
        check_eq({tag, " end_s_ready"}, 64'(s_ready), 64'd1);
    endtask

    function automatic logic [E*DW-1:0] make_diag(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                  input logic [DW-1:0] d2);
        logic [E*DW-1:0] m;
        m = '0;
        m[0*DW +: DW] = d0;
        m[4*DW +: DW] = d1;
        m[8*DW +: DW] = d2;
        return m;
    endfunction

    initial begin
        logic [E*DW-1:0] ident;
        logic [E*DW-1:0] diag2;
        logic [E*DW-1:0] ones;
        logic [E*DW-1:0] m;
        int              kind;

        ident = make_diag(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        diag2 = make_diag(32'h0002_0000, 32'h0002_0000, 32'h0002_0000);
        ones  = {E{32'h0001_0000}};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_s_ready", 64'(s_ready), 64'd0);
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_flags", 64'({m_last, m_singular, m_timeout, core_rst}), 64'd0);
        check_eq("rst_core_matrix", 64'(core_matrix == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_release_s_ready", 64'(s_ready), 64'd1);

        run_job("identity", ident, 0, 2, 1'b0, 1'b0, 0, 1'b0);
        run_job("diag2", diag2, 1, 0, 1'b0, 1'b0, 0, 1'b0);
        run_job("all_ones", ones, 2, 4, 1'b0, 1'b0, 0, 1'b0);
        run_job("identity_stall", ident, 0, 3, 1'b0, 1'b1, 1, 1'b0);
        run_job("hang", ident, 1, 0, 1'b1, 1'b0, 0, 1'b0);
        run_job("complete_at_limit", diag2, 0, 13, 1'b0, 1'b0, 2, 1'b0);
        run_job("complete_too_late", diag2, 0, 14, 1'b0, 1'b0, 0, 1'b0);
        run_job("rst_mid_unload", ident, 0, 1, 1'b0, 1'b0, 0, 1'b1);
        run_job("identity_after_rst", ident, 0, 1, 1'b0, 1'b0, 0, 1'b0);

        for (int j = 0; j < 14; j++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: m = make_diag(32'($urandom_range(32'h100, 32'h7F_FFFF)),
                                 32'($urandom_range(32'h100, 32'h7F_FFFF)),
                                 32'($urandom_range(32'h100, 32'h7F_FFFF)));
                1: begin
                    for (int i = 0; i < E; i++) m[i*DW +: DW] = $urandom;
                end
                default: m = ident;
            endcase
            run_job($sformatf("rand%0d", j), m, $urandom_range(0, 3), $urandom_range(0, 14),
                    (kind == 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
